fifo_status_led: RTL

FIFO_STATUS_LED -- requirements
Module: fifo_status_led

---
 rtl/fifo_status_led.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_status_led.sv
// -----------------------------------------------------------------------------
// fifo_status_led
// Status LED driver for the FIFO demo. Synchronizes the asynchronous FIFO flags
// into led_clk, latches compare errors, stretches the full/empty flags so short
// events stay visible, counts full/empty events, watches a heartbeat for
// stalls, and encodes overall health on a single blinking status LED.
//
// Ports
//   led_clk        : sole clock
//   sys_rst        : asynchronous active-high reset
//   rdata_error_i  : FIFO compare-error flag (async)
//   fifo_full_i    : FIFO full flag (async)
//   fifo_empty_i   : FIFO empty flag (async)
//   alive_i        : heartbeat toggle (async)
//   clr_n_i        : push-button clear, active-low (async)
//   led_status     : health pattern (OK slow blink, WARN fast blink,
//                    ERROR steady on, STALL off)
//   led_error      : sticky error LED
//   led_full       : stretched full LED
//   led_empty      : stretched empty LED
//   full_evt_cnt   : saturating count of full rising edges
//   empty_evt_cnt  : saturating count of empty rising edges
//   state_o        : 00 OK, 01 WARN, 10 ERROR, 11 STALL
// -----------------------------------------------------------------------------
module fifo_status_led #(
  parameter int unsigned SYNC_STAGE     = 2,
  parameter int unsigned STRETCH_CYCLES = 1000000,
  parameter int unsigned BLINK_DIV_W    = 22,
  parameter int unsigned WDOG_CYCLES    = 4000000
) (
  input  logic        led_clk,
  input  logic        sys_rst,
  input  logic        rdata_error_i,
  input  logic        fifo_full_i,
  input  logic        fifo_empty_i,
  input  logic        alive_i,
  input  logic        clr_n_i,
  output logic        led_status,
  output logic        led_error,
  output logic        led_full,
  output logic        led_empty,
  output logic [15:0] full_evt_cnt,
  output logic [15:0] empty_evt_cnt,
  output logic [1:0]  state_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned STR_W  = (STRETCH_CYCLES < 1) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam int unsigned WDOG_W = (WDOG_CYCLES < 1) ? 1 : $clog2(WDOG_CYCLES + 1);

  localparam logic [STR_W-1:0]  STR_LOAD = STR_W'(STRETCH_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_WARN  = 2'b01,
    ST_ERROR = 2'b10,
    ST_STALL = 2'b11
  } state_t;

  // Synchronizer chains; bit SYNC_STAGE-1 is the synchronized value
  logic [SYNC_STAGE-1:0] r_sync_err;
  logic [SYNC_STAGE-1:0] r_sync_full;
  logic [SYNC_STAGE-1:0] r_sync_empty;
  logic [SYNC_STAGE-1:0] r_sync_alive;
  logic [SYNC_STAGE-1:0] r_sync_clr;

  logic w_err_s;
  logic w_full_s;
  logic w_empty_s;
  logic w_alive_s;
  logic w_clr_s;

  // Previous synced values for edge detection
  logic r_full_d;
  logic r_empty_d;
  logic r_alive_d;

  logic w_full_rise;
  logic w_empty_rise;
  logic w_alive_chg;

  logic [CNT_W-1:0]       r_full_cnt;
  logic [CNT_W-1:0]       r_empty_cnt;
  logic [STR_W-1:0]       r_full_str;
  logic [STR_W-1:0]       r_empty_str;
  logic                   r_led_full;
  logic                   r_led_empty;
  logic                   r_led_error;
  logic [WDOG_W-1:0]      r_wdog;
  logic                   w_stall;
  logic [BLINK_DIV_W-1:0] r_div;
  logic                   w_slow;
  logic                   w_fast;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_led_status;
  logic   w_status_nxt;

  // Input synchronizers; the clear chain idles released (high)
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync_err   <= '0;
      r_sync_full  <= '0;
      r_sync_empty <= '0;
      r_sync_alive <= '0;
      r_sync_clr   <= '1;
    end else begin
      r_sync_err   <= {r_sync_err[SYNC_STAGE-2:0],   rdata_error_i};
      r_sync_full  <= {r_sync_full[SYNC_STAGE-2:0],  fifo_full_i};
      r_sync_empty <= {r_sync_empty[SYNC_STAGE-2:0], fifo_empty_i};
      r_sync_alive <= {r_sync_alive[SYNC_STAGE-2:0], alive_i};
      r_sync_clr   <= {r_sync_clr[SYNC_STAGE-2:0],   clr_n_i};
    end
  end

  assign w_err_s   = r_sync_err[SYNC_STAGE-1];
  assign w_full_s  = r_sync_full[SYNC_STAGE-1];
  assign w_empty_s = r_sync_empty[SYNC_STAGE-1];
  assign w_alive_s = r_sync_alive[SYNC_STAGE-1];
  assign w_clr_s   = r_sync_clr[SYNC_STAGE-1];

  // Delayed synced flags for edge detection
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_full_d  <= 1'b0;
      r_empty_d <= 1'b0;
      r_alive_d <= 1'b0;
    end else begin
      r_full_d  <= w_full_s;
      r_empty_d <= w_empty_s;
      r_alive_d <= w_alive_s;
    end
  end

  assign w_full_rise  = w_full_s  & ~r_full_d;
  assign w_empty_rise = w_empty_s & ~r_empty_d;
  assign w_alive_chg  = w_alive_s ^ r_alive_d;

  // Saturating event counters; clear beats a simultaneous increment
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_full_cnt  <= '0;
      r_empty_cnt <= '0;
    end else if (!w_clr_s) begin
      r_full_cnt  <= '0;
      r_empty_cnt <= '0;
    end else begin
      if (w_full_rise && (r_full_cnt != '1)) begin
        r_full_cnt <= r_full_cnt + CNT_W'(1);
      end else begin
        r_full_cnt <= r_full_cnt;
      end
      if (w_empty_rise && (r_empty_cnt != '1)) begin
        r_empty_cnt <= r_empty_cnt + CNT_W'(1);
      end else begin
        r_empty_cnt <= r_empty_cnt;
      end
    end
  end

  // Pulse stretchers: reload while flag is high, count down afterwards
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_full_str  <= '0;
      r_empty_str <= '0;
      r_led_full  <= 1'b0;
      r_led_empty <= 1'b0;
    end else begin
      if (w_full_s) begin
        r_full_str <= STR_LOAD;
      end else if (r_full_str != '0) begin
        r_full_str <= r_full_str - STR_W'(1);
      end
      if (w_empty_s) begin
        r_empty_str <= STR_LOAD;
      end else if (r_empty_str != '0) begin
        r_empty_str <= r_empty_str - STR_W'(1);
      end
      r_led_full  <= w_full_s  | (r_full_str  != '0);
      r_led_empty <= w_empty_s | (r_empty_str != '0);
    end
  end

  // Sticky error; a live error overrides a pending clear
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_led_error <= 1'b0;
    end else if (w_err_s) begin
      r_led_error <= 1'b1;
    end else if (!w_clr_s) begin
      r_led_error <= 1'b0;
    end
  end

  // Heartbeat watchdog, saturating at the stall threshold
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wdog <= '0;
    end else if (w_alive_chg) begin
      r_wdog <= '0;
    end else if (r_wdog != WDOG_MAX) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_stall = (r_wdog == WDOG_MAX);

  // Free-running blink divider
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + BLINK_DIV_W'(1);
    end
  end

  assign w_slow = r_div[BLINK_DIV_W-1];
  assign w_fast = r_div[BLINK_DIV_W-3];

  // Health FSM state and status LED registers
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= ST_OK;
      r_led_status <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_led_status <= w_status_nxt;
    end
  end

  // Next state is a pure priority decode so every state is one cycle away;
  // the LED pattern follows the next state so both update on the same edge
  always_comb begin
    w_state_nxt  = ST_OK;
    w_status_nxt = 1'b0;
    if (w_stall) begin
      w_state_nxt = ST_STALL;
    end else if (r_led_error) begin
      w_state_nxt = ST_ERROR;
    end else if (r_led_full) begin
      w_state_nxt = ST_WARN;
    end
    case (w_state_nxt)
      ST_OK:    w_status_nxt = w_slow;
      ST_WARN:  w_status_nxt = w_fast;
      ST_ERROR: w_status_nxt = 1'b1;
      ST_STALL: w_status_nxt = 1'b0;
      default:  w_status_nxt = 1'b0;
    endcase
  end

  assign led_status    = r_led_status;
  assign led_error     = r_led_error;
  assign led_full      = r_led_full;
  assign led_empty     = r_led_empty;
  assign full_evt_cnt  = r_full_cnt;
  assign empty_evt_cnt = r_empty_cnt;
  assign state_o       = r_state;

endmodule
